// File: rtl/comparador_serial_i_d_if.sv
//------------------------------------------------------------------------------
// Module      : comparador_serial_i_d_if
// Description : Bit-pair stream and result bundle for the MSB-first comparator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface comparador_serial_i_d_if;
    logic start;
    logic bit_valid;
    logic a_p;
    logic b_p;
    logic busy;
    logic decidido;
    logic done;
    logic mayor;
    logic menor;
    logic igual;

    modport master (
        output start, bit_valid, a_p, b_p,
        input  busy, decidido, done, mayor, menor, igual
    );

    modport slave (
        input  start, bit_valid, a_p, b_p,
        output busy, decidido, done, mayor, menor, igual
    );
endinterface

`default_nettype wire

// File: rtl/comparador_serial_i_d.sv
//------------------------------------------------------------------------------
// Module      : comparador_serial_i_d
// Description : MSB-first bit-serial unsigned magnitude comparator; the relation
//               locks at the first differing bit pair.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module comparador_serial_i_d #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    comparador_serial_i_d_if.slave  bus
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    state_t           r_state, w_state_next;
    rel_t             r_rel, w_rel_next, w_rel_upd;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_busy, w_busy_next;
    logic             r_decidido, w_decidido_next;
    logic             r_done, w_done_next;
    logic             r_mayor, w_mayor_next;
    logic             r_menor, w_menor_next;
    logic             r_igual, w_igual_next;

    // Relation after absorbing the current bit pair; once decided it never moves.
    always_comb begin
        w_rel_upd = r_rel;
        if (r_rel == REL_EQ && bus.a_p != bus.b_p) begin
            w_rel_upd = bus.a_p ? REL_GT : REL_LT;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rel_next      = r_rel;
        w_cnt_next      = r_cnt;
        w_busy_next     = r_busy;
        w_decidido_next = r_decidido;
        w_done_next     = 1'b0;
        w_mayor_next    = r_mayor;
        w_menor_next    = r_menor;
        w_igual_next    = r_igual;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next    = S_COMPARE;
                    w_cnt_next      = '0;
                    w_rel_next      = REL_EQ;
                    w_busy_next     = 1'b1;
                    w_decidido_next = 1'b0;
                    w_mayor_next    = 1'b0;
                    w_menor_next    = 1'b0;
                    w_igual_next    = 1'b0;
                end
            end
            S_COMPARE: begin
                if (bus.bit_valid) begin
                    w_rel_next      = w_rel_upd;
                    w_decidido_next = (w_rel_upd != REL_EQ);
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_next = S_DONE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_mayor_next = (w_rel_upd == REL_GT);
                        w_menor_next = (w_rel_upd == REL_LT);
                        w_igual_next = (w_rel_upd == REL_EQ);
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rel      <= REL_EQ;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_decidido <= 1'b0;
            r_done     <= 1'b0;
            r_mayor    <= 1'b0;
            r_menor    <= 1'b0;
            r_igual    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rel      <= w_rel_next;
            r_cnt      <= w_cnt_next;
            r_busy     <= w_busy_next;
            r_decidido <= w_decidido_next;
            r_done     <= w_done_next;
            r_mayor    <= w_mayor_next;
            r_menor    <= w_menor_next;
            r_igual    <= w_igual_next;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.decidido = r_decidido;
    assign bus.done     = r_done;
    assign bus.mayor    = r_mayor;
    assign bus.menor    = r_menor;
    assign bus.igual    = r_igual;

endmodule

`default_nettype wire

// File: tb/tb_comparador_serial_i_d.sv
//------------------------------------------------------------------------------
// Module      : tb_comparador_serial_i_d
// Description : Directed bench for the MSB-first serial comparator (N = 8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_comparador_serial_i_d;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   t0;
    logic [7:0] va;
    logic [7:0] vb;

    comparador_serial_i_d_if bus ();

    comparador_serial_i_d #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic a, input logic b);
        bus.bit_valid = 1'b1;
        bus.a_p       = a;
        bus.b_p       = b;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic do_start();
        t0        = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic m, input logic l, input logic e);
        chk({tag, "_done"},  bus.done,  1'b1);
        chk({tag, "_busy"},  bus.busy,  1'b0);
        chk({tag, "_mayor"}, bus.mayor, m);
        chk({tag, "_menor"}, bus.menor, l);
        chk({tag, "_igual"}, bus.igual, e);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        t0            = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_p       = 1'b1;
        bus.b_p       = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy",     bus.busy,     1'b0);
        chk("rst_decidido", bus.decidido, 1'b0);
        chk("rst_done",     bus.done,     1'b0);
        chk("rst_mayor",    bus.mayor,    1'b0);
        chk("rst_menor",    bus.menor,    1'b0);
        chk("rst_igual",    bus.igual,    1'b0);

        // Idle bits without start must not begin a comparison
        send_bit(1'b1, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);

        // Test 1: 0xA5 vs 0x5A, continuous valid
        va = 8'hA5;
        vb = 8'h5A;
        do_start();
        chk("t1_busy", bus.busy, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            send_bit(va[i], vb[i]);
            if (i == 7) chk("t1_decidido_first", bus.decidido, 1'b1);
            if (i > 0)  chk("t1_no_early_done", bus.done, 1'b0);
        end
        chk_int("t1_latency", cyc - t0, 9);
        chk_result("t1", 1'b1, 1'b0, 1'b0);
        tick();
        chk("t1_done_drop", bus.done,  1'b0);
        chk("t1_mayor_hold", bus.mayor, 1'b1);

        // Test 2: equal operands
        va = 8'h3C;
        vb = 8'h3C;
        do_start();
        chk("t2_clear_mayor", bus.mayor, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(va[i], vb[i]);
            chk("t2_decidido_low", bus.decidido, 1'b0);
        end
        chk_int("t2_latency", cyc - t0, 9);
        chk_result("t2", 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("t2_igual_hold", bus.igual, 1'b1);
        chk("t2_done_low",   bus.done,  1'b0);

        // Test 3: 0x80 vs 0x81 with 3-cycle gaps after bits 2 and 6
        va = 8'h80;
        vb = 8'h81;
        do_start();
        for (int i = 7; i >= 0; i--) begin
            send_bit(va[i], vb[i]);
            if (i > 0) chk("t3_decidido_low", bus.decidido, 1'b0);
            if (i == 6 || i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    chk("t3_busy_gap", bus.busy, 1'b1);
                    chk("t3_done_gap", bus.done, 1'b0);
                end
            end
        end
        chk("t3_decidido_last", bus.decidido, 1'b1);
        chk_int("t3_latency", cyc - t0, 15);
        chk_result("t3", 1'b0, 1'b1, 1'b0);
        tick();

        // Test 4: 0xF0 vs 0x0F with start pulses at bits 3 and 7 and in DONE
        va = 8'hF0;
        vb = 8'h0F;
        do_start();
        for (int i = 7; i >= 0; i--) begin
            bus.start = (i == 5 || i == 1);
            send_bit(va[i], vb[i]);
            bus.start = 1'b0;
            if (i > 0) chk("t4_no_early_done", bus.done, 1'b0);
        end
        chk_int("t4_latency", cyc - t0, 9);
        chk_result("t4", 1'b1, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t4_done_once",     bus.done,  1'b0);
        chk("t4_start_ignored", bus.busy,  1'b0);
        chk("t4_mayor_hold",    bus.mayor, 1'b1);
        do_start();
        chk("t4_new_busy",     bus.busy,     1'b1);
        chk("t4_new_mayor",    bus.mayor,    1'b0);
        chk("t4_new_decidido", bus.decidido, 1'b0);
        va = 8'h01;
        vb = 8'h02;
        for (int i = 7; i >= 0; i--) send_bit(va[i], vb[i]);
        chk_result("t4b", 1'b0, 1'b1, 1'b0);
        tick();

        // Test 5: reset mid-comparison of 0x12 vs 0x34
        va = 8'h12;
        vb = 8'h34;
        do_start();
        for (int i = 7; i >= 4; i--) send_bit(va[i], vb[i]);
        chk("t5_decidido_pre", bus.decidido, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy",     bus.busy,     1'b0);
        chk("t5_decidido", bus.decidido, 1'b0);
        chk("t5_done",     bus.done,     1'b0);
        chk("t5_mayor",    bus.mayor,    1'b0);
        chk("t5_menor",    bus.menor,    1'b0);
        chk("t5_igual",    bus.igual,    1'b0);
        for (int i = 3; i >= 0; i--) begin
            send_bit(va[i], vb[i]);
            chk("t5_no_done", bus.done, 1'b0);
            chk("t5_idle",    bus.busy, 1'b0);
        end
        va = 8'h34;
        vb = 8'h12;
        do_start();
        for (int i = 7; i >= 0; i--) send_bit(va[i], vb[i]);
        chk_int("t5_latency", cyc - t0, 9);
        chk_result("t5b", 1'b1, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/comparador_serial_i_d.md
Name: comparador_serial_i_d

Overview:
- Bit-serial magnitude comparator that scans left to right (MSB first). It is the left-to-right counterpart of the team's right-to-left iterative comparator cell chain.
- Accepts one bit of A and one bit of B per valid cycle over N cycles.
- Locks the relation at the first differing bit and reports A>B, A<B or A==B after the last bit.
- Sits between the serial shift-register front end and the control unit, which consumes the one-cycle done pulse.

Parameters:
N, 8, operand width in bits (N >= 2); also the number of bit pairs accepted per comparison.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset; synchronous and active-high
start  input  1  begin a comparison; honoured only in IDLE
bit_valid  input  1  a_p/b_p carry a valid bit pair this cycle
a_p  input  1  current bit of word A, MSB first
b_p  input  1  current bit of word B, MSB first
busy  output  1  high in COMPARE
decidido  output  1  high once a differing bit pair has been seen in the current comparison
done  output  1  one-cycle pulse when the result is final
mayor  output  1  A > B, valid from done until the next accepted start
menor  output  1  A < B, same validity as mayor
igual  output  1  A == B, same validity as mayor

Behaviour:
- Reset: the interface uses one clock (clk); reset (rst) is synchronous and active-high. On rst=1 at a clock edge:
  - state=IDLE, bit counter=0, internal relation=EQ.
  - busy, decidido, done, mayor, menor, igual all 0.
  - rst overrides every other input, including mid-comparison. The partial result is discarded and no done is issued.
- States: IDLE, COMPARE, DONE. All outputs are registered.
- IDLE:
  - start=1 -> COMPARE next cycle: counter=0, relation=EQ, busy=1, decidido=0, mayor/menor/igual cleared to 0.
  - a_p/b_p are ignored in IDLE, including in the start cycle.
- COMPARE, bit_valid=1:
  - If relation==EQ and a_p!=b_p: relation becomes GT when a_p=1, LT when b_p=1. decidido=1 from the next cycle.
  - If relation is already GT or LT, later bits never change it.
  - Counter increments by 1.
- COMPARE, bit_valid=0: no state change (stall). Any number of idle cycles is allowed between bits.
- Transition to DONE: the bit_valid=1 cycle with counter==N-1 moves to DONE. In the same edge:
  - busy=0, done=1.
  - mayor/menor/igual load from the final relation; exactly one of the three is 1.
- DONE: lasts exactly one cycle, then IDLE unconditionally. done returns to 0; mayor/menor/igual and decidido hold their values.
- start handling: start in COMPARE or DONE is ignored (not queued). start in IDLE is accepted the cycle after the DONE pulse at the earliest.
- Latency with continuous bit_valid: start at cycle t, bits at t+1..t+N, done=1 at cycle t+N+1.
- Counter: width $clog2(N); never exceeds N-1. It resets to 0 on each accepted start and has no wrap-around path.
- No arithmetic beyond the counter increment; comparison is unsigned.

Test Plan:
1. N=8, rst then start, A=0xA5, B=0x5A streamed MSB first with continuous valid:
   - decidido=1 one cycle after the first bit.
   - done pulses once at start+9 with mayor=1, menor=0, igual=0.
2. A=0x3C, B=0x3C:
   - decidido stays 0 throughout.
   - done at start+9 with igual=1; outputs hold until the next start.
3. A=0x80, B=0x81 with bit_valid low for 3 cycles after bits 2 and 6:
   - decidido=1 only after the last bit.
   - done at start+15 with menor=1; busy stays high across the gaps.
4. start pulsed again at bits 3 and 7 and in the DONE cycle of a 0xF0-vs-0x0F comparison:
   - all ignored; a single done with mayor=1.
   - a new start one cycle later clears the results and begins a fresh comparison.
5. rst=1 after 4 bits of 0x12-vs-0x34:
   - next cycle all outputs are 0 and state is IDLE; no done ever pulses for the aborted comparison.
   - a following 0x34-vs-0x12 comparison gives mayor=1.
